// File: rtl/regfile_reader.sv
// -----------------------------------------------------------------------------
// regfile_reader
//
// Walks a register file through its combinational read port and streams every
// register out over a valid/ready interface, one word per two cycles at best
// (FETCH then SEND). Each word is captured into a holding register in its
// FETCH cycle. It stays stable while the consumer stalls, even if the register
// file changes underneath it.
//
// Ports
//   clk_i      : clock, all state on the rising edge
//   rst_ni     : synchronous active-low reset
//   start_i    : request a full dump (only looked at while idle)
//   abort_i    : drop an in-progress dump (FETCH/SEND only), no done_o
//   rf_addr_o  : register-file read address (current index, 0 while idle)
//   rf_data_i  : combinational read data for rf_addr_o
//   m_valid_o  : output word valid (SEND only)
//   m_ready_i  : consumer accepts word
//   m_data_o   : captured register contents
//   m_addr_o   : register index of m_data_o
//   m_last_o   : marks the word for index NumRegs-1
//   busy_o     : high whenever not idle
//   done_o     : one-cycle pulse after the last word of a completed dump
// -----------------------------------------------------------------------------
module regfile_reader #(
  parameter int NumRegs   = 32,
  parameter int DataWidth = 32,
  localparam int AddressWidth = $clog2(NumRegs)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic [AddressWidth-1:0] rf_addr_o,
  input  logic [DataWidth-1:0]    rf_data_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [DataWidth-1:0]    m_data_o,
  output logic [AddressWidth-1:0] m_addr_o,
  output logic                    m_last_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [AddressWidth-1:0] LastIdx = AddressWidth'(NumRegs - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] index_q, index_d;
  logic [DataWidth-1:0]    hold_q,  hold_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        index_d = '0;
        if (start_i) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (abort_i) begin
          state_d = IDLE;
          index_d = '0;
        end else begin
          hold_d  = rf_data_i;
          state_d = SEND;
        end
      end

      SEND: begin
        // Abort wins over a same-cycle handshake: the word is not transferred.
        if (abort_i) begin
          state_d = IDLE;
          index_d = '0;
        end else if (m_ready_i) begin
          if (index_q == LastIdx) begin
            state_d = DONE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = FETCH;
          end
        end
      end

      DONE: begin
        // Clearing here keeps rf_addr_o at 0 throughout IDLE.
        index_d = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the reset is synchronous, checked inside the clocked
  // block rather than in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      index_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      hold_q  <= hold_d;
    end
  end

  assign rf_addr_o = index_q;
  assign m_valid_o = (state_q == SEND);
  assign m_data_o  = hold_q;
  assign m_addr_o  = index_q;
  assign m_last_o  = (state_q == SEND) && (index_q == LastIdx);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 SHALL have parameter NumRegs, default 32, number of registers scanned per dump.
REQ-002 SHALL have parameter DataWidth, default 32, register word width.
REQ-003 SHALL derive localparam AddressWidth = $clog2(NumRegs), register address width.
REQ-004 SHALL have clk_i  input  1  sole clock; all state updates on posedge clk_i.
REQ-005 SHALL have rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have start_i  input  1  request a full dump; sampled only in IDLE.
REQ-007 SHALL have abort_i  input  1  terminate an in-progress dump.
REQ-008 SHALL have rf_addr_o  output  AddressWidth  address driven to a combinational register-file read port.
REQ-009 SHALL have rf_data_i  input  DataWidth  combinational read data for rf_addr_o.
REQ-010 SHALL have m_valid_o  output  1  output word valid.
REQ-011 SHALL have m_ready_i  input  1  downstream accepts word.
REQ-012 SHALL have m_data_o  output  DataWidth  register contents.
REQ-013 SHALL have m_addr_o  output  AddressWidth  register index of m_data_o.
REQ-014 SHALL have m_last_o  output  1  high with the word for index NumRegs-1.
REQ-015 SHALL have busy_o  output  1  high in any state other than IDLE.
REQ-016 SHALL have done_o  output  1  one-cycle pulse on completed (non-aborted) dump.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, SEND, DONE.
REQ-018 SHALL transition IDLE->FETCH on start_i=1, loading index counter to 0.
REQ-019 SHALL, in FETCH, drive rf_addr_o = index and capture rf_data_i into a holding register at the clock edge, then go to SEND (exactly 1 cycle in FETCH).
REQ-020 SHALL, in SEND, hold m_valid_o=1 with m_data_o, m_addr_o, m_last_o stable until m_valid_o && m_ready_i.
REQ-021 SHALL, on a SEND handshake with index < NumRegs-1, increment index and go to FETCH.
REQ-022 SHALL, on a SEND handshake with index = NumRegs-1, go to DONE; index SHALL NOT wrap or be reused.
REQ-023 SHALL assert done_o for exactly the one cycle spent in DONE, then return to IDLE.
REQ-024 SHALL keep m_valid_o=0 in IDLE, FETCH, DONE.
REQ-025 SHALL ignore start_i outside IDLE; no queuing of requests.
REQ-026 SHALL, on abort_i=1 in FETCH or SEND, go to IDLE next cycle, drop m_valid_o, and not assert done_o; abort_i has priority over a simultaneous handshake (word counts as not transferred).
REQ-027 SHALL ignore abort_i in IDLE and DONE.
REQ-028 SHALL emit index 0 like any other register (value as returned by rf_data_i).
REQ-029 SHALL treat a dump as non-atomic: each word reflects rf_data_i at its FETCH cycle.
REQ-030 SHALL hold rf_addr_o at the current index in all states (0 in IDLE).
REQ-031 SHALL produce the first m_valid_o two cycles after the cycle start_i is sampled; minimum dump length 2*NumRegs+2 cycles with m_ready_i tied high.
REQ-032 SHALL tolerate m_ready_i asserted while m_valid_o=0 without effect.

Reset
REQ-033 SHALL, when rst_ni=0 at a clock edge, enter IDLE, clear index, holding register and outputs: m_valid_o=0, m_data_o=0, m_addr_o=0, m_last_o=0, busy_o=0, done_o=0, rf_addr_o=0.
REQ-034 SHALL apply reset mid-dump identically, without emitting done_o.
REQ-035 SHALL give reset priority over start_i and abort_i.

Verification
REQ-036 Reset then start_i pulse, m_ready_i=1, model register file reg[i]=i*0x11111111 (reg0=0) -> 32 words, addr 0..31 in order, data match, m_last_o only on addr 31, done_o one pulse at cycle 66 after start, busy_o low after.
REQ-037 Random m_ready_i stalls -> m_data_o/m_addr_o/m_last_o stable while m_valid_o=1 and m_ready_i=0; no word lost or duplicated.
REQ-038 abort_i during SEND of addr 5 with m_ready_i=1 same cycle -> m_valid_o=0 next cycle, busy_o=0, no done_o; next start_i restarts at addr 0.
REQ-039 start_i held high throughout dump -> single dump of 32 words, then new dump starts from IDLE only after DONE.
REQ-040 rst_ni=0 for one cycle at word 10 -> all outputs 0 next cycle, no done_o, FSM IDLE.
REQ-041 Register file written (reg3=0xDEADBEEF) after its FETCH but before its handshake -> m_data_o shows pre-write value.
